uart_rcv_ctrl: RTL and testbench
================================

# uart_rcv_ctrl

Receive-side control and datapath for the UART receiver. It sits downstream of the two flexible counters that form the bit timer: it consumes their rollover flags and drives their clear/enable inputs. The block synchronizes the serial line, detects the start bit, sequences a frame, shifts in the data, checks the stop bit, and holds the received byte in an output buffer with ready, overrun and framing status.

## Interface
- DATA_BITS, 8: data bits per frame, sent LSB first, followed by one stop bit.
- clk  in  1  system clock.
- n_rst  in  1  reset; asynchronous, active-low.
- serial_in  in  1  raw asynchronous serial line; idles high.
- shift_strobe  in  1  one-cycle pulse at each bit centre (rollover flag of the sample counter). Exactly DATA_BITS+1 pulses per frame: data bit 0 first, stop bit last.
- packet_done  in  1  one-cycle pulse (rollover flag of the bit counter). Arrives no earlier than the cycle after the last shift_strobe of the frame.
- data_read  in  1  consumer has taken rx_data; single-cycle pulse.
- timer_clear  out  1  clear for both counters.
- timer_enable  out  1  count enable for the sample counter.
- rx_data  out  DATA_BITS  last received byte.
- data_ready  out  1  rx_data holds unread data.
- overrun_error  out  1  a byte was overwritten before it was read.
- framing_error  out  1  stop bit of the last frame sampled 0.

## Operation
- Synchronizer: 2-flop chain on serial_in gives `sync`. Both flops reset to 1. `sync_prev` is a register of `sync`, also reset to 1.
- start_det = sync_prev & ~sync. It is acted on only in IDLE. No glitch or false-start filtering.
- Shift register, DATA_BITS+1 wide, resets to all ones:
  - On shift_strobe in RECEIVE: shift right, with `sync` entering the MSB.
  - After a full frame: MSB holds the stop bit; [DATA_BITS-1:0] holds the data.
  - shift_strobe is ignored in all other states.
- FSM with states IDLE, CLEAR, RECEIVE, STOP_CHECK, LOAD. Reset state is IDLE.
  - IDLE -> CLEAR on start_det; otherwise stay.
  - CLEAR -> RECEIVE unconditionally. timer_clear=1 in CLEAR only. framing_error is cleared on leaving CLEAR.
  - RECEIVE -> STOP_CHECK on packet_done. timer_enable=1 in RECEIVE only.
  - STOP_CHECK: if the shift register MSB is 0, set framing_error and go to IDLE; the byte is discarded. Otherwise go to LOAD.
  - LOAD -> IDLE. On that edge: rx_data <= shift[DATA_BITS-1:0] and data_ready <= 1.
- data_ready:
  - Cleared on the edge after data_read.
  - If LOAD and data_read occur in the same cycle, the new data is loaded and data_ready stays 1.
- overrun_error:
  - Set on LOAD when data_ready=1 and data_read=0.
  - Cleared on the edge after data_read.
  - If LOAD and data_read occur in the same cycle: no overrun, and any existing overrun is cleared.
- framing_error holds until the next CLEAR.
- A falling edge on the line while not in IDLE is ignored. The stop bit guarantees the line is high again before the next frame.
- Reset mid-frame: every register returns to its reset value immediately, and the partial frame is lost.

## Timing
- Reset values: timer_clear=0, timer_enable=0, rx_data=0, data_ready=0, overrun_error=0, framing_error=0. FSM in IDLE.
- Start latency (edges numbered from the first edge that samples serial_in low as k):
  - sync=0 after k+1.
  - State is CLEAR after k+2; timer_clear is high for that one cycle.
  - State is RECEIVE after k+3.
- Load latency: with packet_done high in cycle c (edges after c numbered e1-e3):
  - STOP_CHECK after e1.
  - framing_error updates, or LOAD is entered, at e2.
  - rx_data and data_ready valid after e3.
- Outputs are registered except timer_clear and timer_enable, which are Moore decodes of the state register.

## Test plan
- Reset: assert n_rst low mid-run -> all outputs 0 and FSM in IDLE, asynchronously. serial_in held high -> no state change.
- Clean frame 0xA5: drive a falling edge, then 9 strobes with line bits 1,0,1,0,0,1,0,1 and stop=1, then packet_done -> timer_clear high for exactly 1 cycle, rx_data=0xA5 and data_ready=1 at e3, framing_error=0. data_read -> data_ready=0 on the next edge.
- Framing error: frame 0x3C with stop bit 0 -> framing_error=1 at e2, data_ready stays 0, rx_data unchanged. Next valid frame -> framing_error=0 after CLEAR.
- Overrun: receive 0x11 without reading, then 0x22 -> rx_data=0x22, overrun_error=1. data_read -> data_ready=0 and overrun_error=0.
- Simultaneous load and read: pulse data_read in the LOAD cycle of the second frame -> rx_data holds the new byte, data_ready=1, overrun_error=0.
- Mid-frame reset: reset after 4 strobes, then send a full frame 0xFF -> rx_data=0xFF, with no residue from the aborted frame.

Source files
------------

// File: rtl/uart_rcv_ctrl.sv
// UART receive control: line synchronizer, start detect, frame FSM, shift register and output buffer.
// Drives the bit-timer clear/enable and holds the last byte with ready/overrun/framing status.
module uart_rcv_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 shift_strobe,
    input  logic                 packet_done,
    input  logic                 data_read,
    output logic                 timer_clear,
    output logic                 timer_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RECEIVE,
        STOP_CHECK,
        LOAD
    } state_t;

    state_t               state_q, state_d;
    logic                 sync_meta_q;
    logic                 sync_q;
    logic                 sync_prev_q;
    logic [DATA_BITS:0]   shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 data_ready_q;
    logic                 overrun_q;
    logic                 framing_q;
    logic                 start_det;

    assign start_det = sync_prev_q & ~sync_q;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start after reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_meta_q <= 1'b1;
            sync_q      <= 1'b1;
            sync_prev_q <= 1'b1;
        end else begin
            sync_meta_q <= serial_in;
            sync_q      <= sync_meta_q;
            sync_prev_q <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                timer_clear = 1'b1;
                state_d     = RECEIVE;
            end
            RECEIVE: begin
                timer_enable = 1'b1;
                if (packet_done) begin
                    state_d = STOP_CHECK;
                end
            end
            STOP_CHECK: begin
                state_d = shift_q[DATA_BITS] ? LOAD : IDLE;
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // LSB arrives first, so shifting right leaves the stop bit in the MSB after a full frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_q <= '1;
        end else if ((state_q == RECEIVE) && shift_strobe) begin
            shift_q <= {sync_q, shift_q[DATA_BITS:1]};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_q    <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (state_q == LOAD) begin
            rx_data_q    <= shift_q[DATA_BITS-1:0];
            data_ready_q <= 1'b1;
            // A read in the load cycle consumes the old byte, so nothing is lost.
            if (data_read) begin
                overrun_q <= 1'b0;
            end else if (data_ready_q) begin
                overrun_q <= 1'b1;
            end
        end else if (data_read) begin
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            framing_q <= 1'b0;
        end else if (state_q == CLEAR) begin
            framing_q <= 1'b0;
        end else if ((state_q == STOP_CHECK) && !shift_q[DATA_BITS]) begin
            framing_q <= 1'b1;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;

endmodule

// File: tb/tb_uart_rcv_ctrl.sv
// Directed bench for uart_rcv_ctrl: the bench plays the bit timer, driving strobes and packet_done by hand.
module tb_uart_rcv_ctrl;

    logic       clk;
    logic       n_rst;
    logic       serial_in;
    logic       shift_strobe;
    logic       packet_done;
    logic       data_read;
    logic       timer_clear;
    logic       timer_enable;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;

    int tests;
    int fails;

    uart_rcv_ctrl #(.DATA_BITS(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .shift_strobe  (shift_strobe),
        .packet_done   (packet_done),
        .data_read     (data_read),
        .timer_clear   (timer_clear),
        .timer_enable  (timer_enable),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (3) tick();
        shift_strobe = 1'b1;
        tick();
        shift_strobe = 1'b0;
    endtask

    task automatic do_read();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
    endtask

    // Full frame from the falling start edge to e3; returns with the line high and the FSM idle.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic rd_in_load);
        serial_in = 1'b0;
        tick();
        tick();
        tests++;
        if (timer_clear !== 1'b0) begin
            fails++;
            $display("FAIL clear_early: timer_clear=%b want 0", timer_clear);
        end
        tick();
        tests++;
        if (timer_clear !== 1'b1) begin
            fails++;
            $display("FAIL clear_pulse: timer_clear=%b want 1", timer_clear);
        end
        tick();
        tests++;
        if ({timer_clear, timer_enable, framing_error} !== 3'b010) begin
            fails++;
            $display("FAIL receive_entry: clr/en/fe=%b want 010", {timer_clear, timer_enable, framing_error});
        end
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i]);
        end
        drive_bit(stop_bit);
        packet_done = 1'b1;
        tick();
        packet_done = 1'b0;
        tick();
        tests++;
        if ({timer_enable, framing_error} !== {1'b0, ~stop_bit}) begin
            fails++;
            $display("FAIL e2_status: en/fe=%b want %b", {timer_enable, framing_error}, {1'b0, ~stop_bit});
        end
        if (rd_in_load) data_read = 1'b1;
        tick();
        data_read = 1'b0;
        serial_in = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic moved;
        n_rst = 1'b0;
        #3;
        tests++;
        if ({timer_clear, timer_enable, rx_data, data_ready, overrun_error, framing_error} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 0",
                     {timer_clear, timer_enable, rx_data, data_ready, overrun_error, framing_error});
        end
        tick();
        n_rst = 1'b1;
        moved = 1'b0;
        repeat (12) begin
            tick();
            if (timer_clear || timer_enable || data_ready) moved = 1'b1;
        end
        tests++;
        if (moved !== 1'b0) begin
            fails++;
            $display("FAIL idle_high_line: activity=%b want 0", moved);
        end
    endtask

    task automatic test_clean_frame();
        send_frame(8'hA5, 1'b1, 1'b0);
        tests++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {8'hA5, 3'b100}) begin
            fails++;
            $display("FAIL clean_A5: rx/dr/fe/ov=%h/%b%b%b want a5/100", rx_data, data_ready, framing_error, overrun_error);
        end
        do_read();
        tests++;
        if (data_ready !== 1'b0) begin
            fails++;
            $display("FAIL clean_read: data_ready=%b want 0", data_ready);
        end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0);
        tests++;
        if ({rx_data, data_ready, framing_error} !== {8'hA5, 2'b01}) begin
            fails++;
            $display("FAIL framing_3C: rx/dr/fe=%h/%b%b want a5/01", rx_data, data_ready, framing_error);
        end
        send_frame(8'h5A, 1'b1, 1'b0);
        tests++;
        if ({rx_data, data_ready, framing_error} !== {8'h5A, 2'b10}) begin
            fails++;
            $display("FAIL framing_recover: rx/dr/fe=%h/%b%b want 5a/10", rx_data, data_ready, framing_error);
        end
        do_read();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 1'b0);
        tests++;
        if ({rx_data, data_ready, overrun_error} !== {8'h11, 2'b10}) begin
            fails++;
            $display("FAIL overrun_first: rx/dr/ov=%h/%b%b want 11/10", rx_data, data_ready, overrun_error);
        end
        send_frame(8'h22, 1'b1, 1'b0);
        tests++;
        if ({rx_data, data_ready, overrun_error} !== {8'h22, 2'b11}) begin
            fails++;
            $display("FAIL overrun_second: rx/dr/ov=%h/%b%b want 22/11", rx_data, data_ready, overrun_error);
        end
        do_read();
        tests++;
        if ({data_ready, overrun_error} !== 2'b00) begin
            fails++;
            $display("FAIL overrun_read: dr/ov=%b want 00", {data_ready, overrun_error});
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        tests++;
        if ({rx_data, overrun_error} !== {8'h55, 1'b1}) begin
            fails++;
            $display("FAIL b2b_setup: rx/ov=%h/%b want 55/1", rx_data, overrun_error);
        end
        send_frame(8'h44, 1'b1, 1'b1);
        tests++;
        if ({rx_data, data_ready, overrun_error} !== {8'h44, 2'b10}) begin
            fails++;
            $display("FAIL load_and_read: rx/dr/ov=%h/%b%b want 44/10", rx_data, data_ready, overrun_error);
        end
        do_read();
    endtask

    task automatic test_mid_reset();
        serial_in = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            drive_bit(1'b0);
        end
        #2;
        n_rst = 1'b0;
        #1;
        tests++;
        if ({timer_clear, timer_enable, rx_data, data_ready, overrun_error, framing_error} !== 13'd0) begin
            fails++;
            $display("FAIL mid_reset_async: got %b want 0",
                     {timer_clear, timer_enable, rx_data, data_ready, overrun_error, framing_error});
        end
        serial_in = 1'b1;
        tick();
        n_rst = 1'b1;
        repeat (4) tick();
        send_frame(8'hFF, 1'b1, 1'b0);
        tests++;
        if ({rx_data, data_ready, overrun_error, framing_error} !== {8'hFF, 3'b100}) begin
            fails++;
            $display("FAIL after_reset_FF: rx/dr/ov/fe=%h/%b%b%b want ff/100", rx_data, data_ready, overrun_error, framing_error);
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        serial_in    = 1'b1;
        shift_strobe = 1'b0;
        packet_done  = 1'b0;
        data_read    = 1'b0;
        n_rst        = 1'b1;
        test_reset();
        test_clean_frame();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
